// File: rtl/dmem_responder_if.sv
// Load/store request/response channel between the memory stage and dmem_responder.
// Latency: none (wires only).
// Backpressure: req_ready throttles requests, rsp_ready holds the response.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Initiator side (execute/memory stage).
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Responder side (data memory).
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with byte strobes answering one load/store at a time.
// Latency: response one cycle after accept; WAIT_CYCLES+1 with DMEM_WAIT_EN defined.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef DMEM_WAIT_EN
    localparam int CW = $clog2((WAIT_CYCLES > 1) ? WAIT_CYCLES : 2);
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
`else
    typedef enum logic {S_IDLE, S_RESP} state_t;
`endif

    state_t            r_state;
    state_t            w_next;
    logic              w_enter_resp;
    logic              w_do_access;
    logic              w_accept;

    logic              w_acc_we;
    logic [31:0]       w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic [3:0]        w_acc_wstrb;
    logic              w_acc_err;
    logic [DEPTH_LOG2-1:0] w_idx;

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [31:0]       r_rdata;
    logic              r_err;

    assign bus.req_ready = (r_state == S_IDLE) & ~reset;
    assign bus.rsp_valid = (r_state == S_RESP) & ~reset;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    assign w_accept = bus.req_valid & bus.req_ready;

`ifdef DMEM_WAIT_EN
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic [CW-1:0] r_cnt;

    // Capture the request on accept so the access can happen after the wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_wstrb <= bus.req_wstrb;
        end
    end

    // Wait-state down-counter: loaded on accept, counts to zero in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Accesses straight from IDLE use the live bus; after WAIT use the captured copy.
    always_comb begin
        w_acc_we    = bus.req_we;
        w_acc_addr  = bus.req_addr;
        w_acc_wdata = bus.req_wdata;
        w_acc_wstrb = bus.req_wstrb;
        if (r_state != S_IDLE) begin
            w_acc_we    = r_we;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
            w_acc_wstrb = r_wstrb;
        end
    end
`else
    // Without wait states the access always happens on the accept edge.
    always_comb begin
        w_acc_we    = bus.req_we;
        w_acc_addr  = bus.req_addr;
        w_acc_wdata = bus.req_wdata;
        w_acc_wstrb = bus.req_wstrb;
    end
`endif

    // Misaligned or beyond the RAM: flagged, never performed.
    assign w_acc_err = (w_acc_addr[1:0] != 2'b00) || ((w_acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign w_idx     = w_acc_addr[DEPTH_LOG2+1:2];

    // Next-state logic; w_enter_resp marks the edge on which the access happens.
    always_comb begin
        w_next       = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef DMEM_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        w_next = S_WAIT;
                    end else begin
                        w_next       = S_RESP;
                        w_enter_resp = 1'b1;
                    end
`else
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
`endif
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_do_access = w_enter_resp & ~reset;

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Byte-strobed store commit; RAM is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (w_do_access && w_acc_we && !w_acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response registers: loaded once on RESP entry and held until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_do_access) begin
            r_err   <= w_acc_err;
            r_rdata <= (w_acc_err || w_acc_we) ? 32'd0 : r_mem[w_idx];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int DEPTH_LOG2  = 8;
    localparam int WAIT_CYCLES = 3;
`ifdef DMEM_WAIT_EN
    localparam int EXP_LAT = WAIT_CYCLES + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; hold = cycles to stall rsp_ready after rsp_valid.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                          output logic [31:0] rdata, output logic err);
        int lat;
        check({tag, "_rdy"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        @(posedge clk); #1;
        // Garbage after acceptance must be ignored.
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0010;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_wstrb = 4'hF;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(EXP_LAT));
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_vld"}, {31'd0, bus.rsp_valid}, 32'd1);
            check({tag, "_hold_rdy"}, {31'd0, bus.req_ready}, 32'd0);
            check({tag, "_hold_dat"}, bus.rsp_rdata, rdata);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, "_done"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        n_assert = 0;
        n_fail   = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Store then load the same word.
        do_req("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        check("st10_rdata", rd, 32'd0);
        check("st10_err", {31'd0, er}, 32'd0);
        do_req("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("ld10_rdata", rd, 32'hDEAD_BEEF);
        check("ld10_err", {31'd0, er}, 32'd0);

        // Byte strobes: bytes 0 and 2 replaced.
        do_req("st20a", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd, er);
        do_req("st20b", 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 0, rd, er);
        do_req("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("ld20_rdata", rd, 32'h11BB_33DD);

        // Zero strobe store is legal and changes nothing.
        do_req("st20z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
        check("st20z_err", {31'd0, er}, 32'd0);
        do_req("ld20z", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("ld20z_rdata", rd, 32'h11BB_33DD);

        // Errors: misaligned, out of range; error stores must not alias.
        do_req("st00", 1'b1, 32'h0, 32'h0102_0304, 4'hF, 0, rd, er);
        do_req("ld22", 1'b0, 32'h22, 32'h0, 4'h0, 0, rd, er);
        check("ld22_err", {31'd0, er}, 32'd1);
        check("ld22_rdata", rd, 32'd0);
        do_req("ld400", 1'b0, 32'h400, 32'h0, 4'h0, 0, rd, er);
        check("ld400_err", {31'd0, er}, 32'd1);
        check("ld400_rdata", rd, 32'd0);
        do_req("st400", 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
        check("st400_err", {31'd0, er}, 32'd1);
        do_req("st22", 1'b1, 32'h22, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
        check("st22_err", {31'd0, er}, 32'd1);
        do_req("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
        check("ld00_rdata", rd, 32'h0102_0304);
        check("ld00_err", {31'd0, er}, 32'd0);
        do_req("ld20e", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("ld20e_rdata", rd, 32'h11BB_33DD);

        // Response held under backpressure for 5 cycles.
        do_req("ldhold", 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
        check("ldhold_rdata", rd, 32'hDEAD_BEEF);

        // Reset together with a request: nothing captured.
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0000_0000;
        bus.req_wstrb = 4'hF;
        @(posedge clk); #1;
        check("rstacc_vld", {31'd0, bus.rsp_valid}, 32'd0);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        do_req("ld10r", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("ld10r_rdata", rd, 32'hDEAD_BEEF);

        // Reset during RESP: response dropped, committed store kept.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h34;
        bus.req_wdata = 32'h0000_0077;
        bus.req_wstrb = 4'hF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rstresp_lat", 32'(lat), 32'(EXP_LAT));
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstresp_vld", {31'd0, bus.rsp_valid}, 32'd0);
        check("rstresp_rdy", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstresp_vld2", {31'd0, bus.rsp_valid}, 32'd0);
        do_req("ld34", 1'b0, 32'h34, 32'h0, 4'h0, 0, rd, er);
        check("ld34_rdata", rd, 32'h0000_0077);

`ifdef DMEM_WAIT_EN
        // Reset mid-WAIT: pending store dropped.
        do_req("st30", 1'b1, 32'h30, 32'h1234_5678, 4'hF, 0, rd, er);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'h0000_0055;
        bus.req_wstrb = 4'hF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset         = 1'b1;
        @(posedge clk); #1;
        check("rstwait_vld", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("rstwait_vld2", {31'd0, bus.rsp_valid}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        do_req("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er);
        check("ld30_rdata", rd, 32'h1234_5678);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the fewcore pipeline's load/store port. It accepts one request at a time over a valid/ready request channel and returns a valid/ready response. It owns a word-organised RAM with per-byte write strobes and flags bad addresses instead of performing the access. It sits between the execute/memory stage (the initiator) and storage, and replaces the fixed-latency data memory wherever stalls on memory latency must be exercised.

## Interface
- DEPTH_LOG2, default 8: RAM holds 2**DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, default 2: extra cycles between request acceptance and response. Honoured only with DMEM_WAIT_EN.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept; equals (state==IDLE) & ~reset.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator consumes response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range request.

## Operation
- States: IDLE, WAIT (only exists with DMEM_WAIT_EN), RESP.
- IDLE: when req_valid & req_ready, capture we/addr/wdata/wstrb.
  - Next state is WAIT if DMEM_WAIT_EN and WAIT_CYCLES>0; otherwise RESP.
- WAIT: a down-counter is loaded with WAIT_CYCLES-1 on accept. Go to RESP when the counter is 0; otherwise decrement.
- The access is performed on the edge that enters RESP. Store bytes commit on that edge. Load data is registered into rsp_rdata on that edge.
- Error condition: addr[1:0]!=0, or addr[31:DEPTH_LOG2+2]!=0.
  - On error: no RAM write, rsp_err=1, rsp_rdata=0.
- Word index is addr[DEPTH_LOG2+1:2].
- Store with wstrb=0: legal; no bytes change; normal response.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready. The state returns to IDLE on that edge.
- Request inputs are ignored while req_ready=0. The initiator must hold them only until acceptance.
- Reset: state goes to IDLE and the counter clears.
  - Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=0 while reset is high.
  - RAM contents are not cleared.

## Timing
- Without DMEM_WAIT_EN: a request accepted at edge N gives rsp_valid high in cycle N+1.
- With DMEM_WAIT_EN: rsp_valid goes high WAIT_CYCLES+1 cycles after the accept edge.
- req_ready rises the cycle after the response handshake. Peak throughput is one request per 2 cycles (no wait states).
- Reset asserted together with an accept: reset wins; nothing is captured or written.
- Reset asserted during WAIT: the pending store is dropped and the RAM is unchanged.
- Reset asserted during RESP: the response is discarded. A store already committed on RESP entry stays committed.
- Load-after-store to the same word returns the new data. The store commits before its response, so this holds.

## Configuration
- DMEM_WAIT_EN defined: the WAIT state, the counter and the WAIT_CYCLES parameter are compiled in.
- DMEM_WAIT_EN undefined: no WAIT state or counter. Fixed 1-cycle latency. WAIT_CYCLES is ignored.

## Test plan
- Macro off, store addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, then load 0x10 → rsp_valid one cycle after each accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte strobes: store 0x11223344 to 0x20 with wstrb=0xF, then 0xAABBCCDD with wstrb=0x5 → load 0x20 returns 0x11BB33DD.
- Errors: load 0x22 (misaligned) and load 0x400 with DEPTH_LOG2=8 → rsp_err=1, rsp_rdata=0; a subsequent load of 0x00 is unaffected.
- Macro on, WAIT_CYCLES=3: load accepted at edge N → rsp_valid first high in cycle N+4. Hold rsp_ready=0 for 5 cycles → rdata stable and req_ready=0 throughout.
- Reset mid-WAIT (macro on): store 0x55 to 0x30, assert reset the cycle after accept → after reset, load 0x30 returns its prior value, and rsp_valid=0 during reset.
